// File: rtl/sramc_writer_pkg.sv
// Shared constants and FSM encoding for the sramC result writer.
package sramc_writer_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 8;
  localparam int DIM_W_DEF  = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sramc_addr_gen.sv
// Multiplier-free row-major address generator for a column-major element stream.
module sramc_addr_gen #(
  parameter int ADDR_W = 11,
  parameter int DIM_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  rows,
  input  logic [DIM_W-1:0]  cols,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [DIM_W-1:0]  rows_q, cols_q, row_cnt, col_cnt;
  logic [ADDR_W-1:0] row_ptr, col_base;
  logic              row_end, col_end;

  assign row_end = (row_cnt == rows_q - DIM_W'(1));
  assign col_end = (col_cnt == cols_q - DIM_W'(1));
  assign last    = row_end && col_end;
  assign addr    = row_ptr;

  // Walking down a column strides by cols; a new column restarts one past the previous column base.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rows_q   <= '0;
      cols_q   <= '0;
      row_cnt  <= '0;
      col_cnt  <= '0;
      row_ptr  <= '0;
      col_base <= '0;
    end else if (load) begin
      rows_q   <= rows;
      cols_q   <= cols;
      row_cnt  <= '0;
      col_cnt  <= '0;
      row_ptr  <= base_addr;
      col_base <= base_addr;
    end else if (step) begin
      if (row_end) begin
        row_cnt  <= '0;
        col_cnt  <= col_cnt + DIM_W'(1);
        col_base <= col_base + ADDR_W'(1);
        row_ptr  <= col_base + ADDR_W'(1);
      end else begin
        row_cnt <= row_cnt + DIM_W'(1);
        row_ptr <= row_ptr + ADDR_W'(cols_q);
      end
    end
  end

endmodule

// File: rtl/sramc_writer.sv
// Drains systolic-array results (column-major) into sramC in row-major layout.
module sramc_writer
  import sramc_writer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  rows,
  input  logic [DIM_W-1:0]  cols,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              sram_en,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_d,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic              load, accept, last;
  logic [ADDR_W-1:0] gen_addr;

  assign load   = (state == S_IDLE) && start;
  assign accept = in_ready && in_valid;

  sramc_addr_gen #(
    .ADDR_W(ADDR_W),
    .DIM_W (DIM_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (accept),
    .base_addr(base_addr),
    .rows     (rows),
    .cols     (cols),
    .addr     (gen_addr),
    .last     (last)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      sram_en   <= 1'b0;
      sram_wen  <= 1'b1;
      sram_addr <= '0;
      sram_d    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Strobes default to idle each cycle; address and data hold between writes.
      sram_en  <= 1'b0;
      sram_wen <= 1'b1;
      done     <= 1'b0;
      if (accept) begin
        sram_en   <= 1'b1;
        sram_wen  <= 1'b0;
        sram_addr <= gen_addr;
        sram_d    <= in_data;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (rows == '0 || cols == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_WRITE;
              in_ready <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (accept && last) begin
            state    <= S_DONE;
            in_ready <= 1'b0;
            done     <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sramc_writer.sv
// Directed bench for sramc_writer with a scoreboard of expected sramC writes.
module tb_sramc_writer;
  import sramc_writer_pkg::*;

  typedef struct {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [ADDR_W_DEF-1:0] base_addr;
  logic [DIM_W_DEF-1:0]  rows, cols;
  logic                  in_valid;
  logic [DATA_W_DEF-1:0] in_data;
  logic                  in_ready, sram_en, sram_wen, busy, done;
  logic [ADDR_W_DEF-1:0] sram_addr;
  logic [DATA_W_DEF-1:0] sram_d;

  int  checks = 0;
  int  errors = 0;
  int  wr_count = 0;
  int  done_count = 0;
  int  ready_count = 0;
  wr_t sb[$];

  sramc_writer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .rows     (rows),
    .cols     (cols),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .sram_en  (sram_en),
    .sram_wen (sram_wen),
    .sram_addr(sram_addr),
    .sram_d   (sram_d),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every sramC write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (sram_en === 1'b1) begin
      wr_t e;
      wr_count++;
      check("no_read", 32'(sram_wen), 32'd0);
      check("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wr_addr", 32'(sram_addr), 32'(e.addr));
        check("wr_data", 32'(sram_d), 32'(e.data));
      end
    end
    if (done === 1'b1) done_count++;
    if (in_ready === 1'b1) ready_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input logic [DATA_W_DEF-1:0] d);
    wr_t e;
    e.addr = ADDR_W_DEF'(a % 2048);
    e.data = d;
    sb.push_back(e);
  endtask

  // Reference layout: column-major stream k lands at base + r*cols + c.
  task automatic push_matrix(input int b, input int r, input int c, input logic [DATA_W_DEF-1:0] d0);
    int k = 0;
    for (int ci = 0; ci < c; ci++) begin
      for (int ri = 0; ri < r; ri++) begin
        push(b + ri * c + ci, d0 + DATA_W_DEF'(k));
        k++;
      end
    end
  endtask

  // Pulse start, then scramble the operands to prove they were latched.
  task automatic launch(input int b, input int r, input int c);
    start     = 1'b1;
    base_addr = ADDR_W_DEF'(b);
    rows      = DIM_W_DEF'(r);
    cols      = DIM_W_DEF'(c);
    tick();
    start     = 1'b0;
    base_addr = '1;
    rows      = 6'd7;
    cols      = 6'd5;
  endtask

  task automatic feed(input int n, input logic [DATA_W_DEF-1:0] d0);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = d0 + DATA_W_DEF'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  int w0, d0, r0;

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; rows = '0; cols = '0;
    in_valid = 1'b0; in_data = '0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_sram_en", 32'(sram_en), 32'd0);
    check("rst_sram_wen", 32'(sram_wen), 32'd1);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_sram_d", 32'(sram_d), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // 2x3 at base 0, back-to-back.
    w0 = wr_count; d0 = done_count;
    push_matrix(0, 2, 3, 8'd1);
    launch(0, 2, 3);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    feed(6, 8'd1);
    wait_done("t1_done_seen");
    check("t1_done_with_write", 32'(sram_en), 32'd1);
    check("t1_done_addr", 32'(sram_addr), 32'd5);
    tick();
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_ready", 32'(in_ready), 32'd0);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);
    check("t1_writes", 32'(wr_count - w0), 32'd6);
    check("t1_dones", 32'(done_count - d0), 32'd1);

    // 2x2 wrapping past the top of sramC.
    w0 = wr_count; d0 = done_count;
    push_matrix(2046, 2, 2, 8'hA);
    launch(2046, 2, 2);
    feed(4, 8'hA);
    wait_done("t2_done_seen");
    check("t2_done_addr", 32'(sram_addr), 32'd1);
    tick();
    check("t2_sb_empty", 32'(sb.size()), 32'd0);
    check("t2_writes", 32'(wr_count - w0), 32'd4);
    check("t2_dones", 32'(done_count - d0), 32'd1);

    // 3x1 with gaps in in_valid.
    w0 = wr_count; d0 = done_count;
    push_matrix(300, 3, 1, 8'h40);
    launch(300, 3, 1);
    in_valid = 1'b1; in_data = 8'h40; tick();
    in_valid = 1'b0; in_data = 8'hFF; tick();
    check("t3_gap_en", 32'(sram_en), 32'd0);
    check("t3_gap_wen", 32'(sram_wen), 32'd1);
    check("t3_gap_addr_hold", 32'(sram_addr), 32'd300);
    check("t3_gap_data_hold", 32'(sram_d), 32'h40);
    in_valid = 1'b1; in_data = 8'h41; tick();
    in_valid = 1'b0; in_data = 8'hEE; tick();
    in_valid = 1'b1; in_data = 8'h42; tick();
    in_valid = 1'b0;
    wait_done("t3_done_seen");
    tick();
    check("t3_sb_empty", 32'(sb.size()), 32'd0);
    check("t3_writes", 32'(wr_count - w0), 32'd3);
    check("t3_dones", 32'(done_count - d0), 32'd1);

    // Zero rows: immediate done, no traffic even with in_valid high.
    w0 = wr_count; d0 = done_count; r0 = ready_count;
    in_valid = 1'b1; in_data = 8'h99;
    launch(7, 0, 5);
    check("t4_done", 32'(done), 32'd1);
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_in_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    check("t4_done_clear", 32'(done), 32'd0);
    check("t4_busy_clear", 32'(busy), 32'd0);
    tick();
    check("t4_writes", 32'(wr_count - w0), 32'd0);
    check("t4_ready_never", 32'(ready_count - r0), 32'd0);
    check("t4_dones", 32'(done_count - d0), 32'd1);

    // Reset after the second of four elements, then a clean rerun.
    w0 = wr_count; d0 = done_count;
    push(50, 8'h20);
    push(52, 8'h21);
    launch(50, 2, 2);
    feed(2, 8'h20);
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h22;
    tick();
    check("t5_rst_en", 32'(sram_en), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    repeat (3) tick();
    check("t5_sb_empty", 32'(sb.size()), 32'd0);
    check("t5_writes", 32'(wr_count - w0), 32'd2);
    check("t5_no_done", 32'(done_count - d0), 32'd0);
    w0 = wr_count; d0 = done_count;
    push_matrix(100, 2, 2, 8'h30);
    launch(100, 2, 2);
    feed(4, 8'h30);
    wait_done("t5_rerun_done");
    tick();
    check("t5_rerun_sb_empty", 32'(sb.size()), 32'd0);
    check("t5_rerun_writes", 32'(wr_count - w0), 32'd4);
    check("t5_rerun_dones", 32'(done_count - d0), 32'd1);

    // start pulsed mid-matrix with other operands must be ignored.
    w0 = wr_count; d0 = done_count;
    push_matrix(10, 2, 3, 8'h60);
    launch(10, 2, 3);
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h60 + 8'(k);
      if (k == 2) begin
        start = 1'b1; base_addr = 11'd500; rows = 6'd1; cols = 6'd1;
      end
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    wait_done("t6_done_seen");
    check("t6_done_with_write", 32'(sram_en), 32'd1);
    check("t6_done_addr", 32'(sram_addr), 32'd15);
    tick();
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
    check("t6_writes", 32'(wr_count - w0), 32'd6);
    check("t6_dones", 32'(done_count - d0), 32'd1);
    check("t6_idle_busy", 32'(busy), 32'd0);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
